// File: rtl/txn_stage_sequencer.sv
// rtl/txn_stage_sequencer.sv - walks a transaction through NUM_STAGES travel/step phase pairs.
// Optional SEQ_TIMEOUT_EN adds a per-phase watchdog and the timeout_flag output.
module txn_stage_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int CODE_W         = 3,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_animation,
  input  logic              done_travel,
  input  logic              done_step,
  input  logic              step_fail,
  input  logic              cancel,
  output logic [CODE_W-1:0] step,
  output logic [CODE_W-1:0] travel,
  output logic              busy,
  output logic              finished_transaction,
  output logic              failed_transaction,
  output logic              pending,
  output logic [CNT_W-1:0]  done_count,
  output logic [CNT_W-1:0]  fail_count
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic              timeout_flag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRAVEL, S_STEP, S_FINAL_TRAVEL, S_DONE, S_FAIL
  } state_t;

  localparam logic [2:0]        LAST_STAGE  = 3'(NUM_STAGES - 1);
  localparam logic [CODE_W-1:0] FINISH_CODE = CODE_W'(NUM_STAGES + 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 7 || (1 << CODE_W) <= NUM_STAGES || TIMEOUT_CYCLES < 2)
  begin : g_bad_params
    $error("txn_stage_sequencer: parameter combination out of range");
  end

  state_t            state;
  state_t            nxt;
  logic [2:0]        stage;
  logic [CODE_W-1:0] stage_code;
  logic              in_phase;
  logic              phase_expired;

  assign stage_code = CODE_W'(stage) + CODE_W'(1);
  assign in_phase   = (state == S_TRAVEL) || (state == S_STEP) || (state == S_FINAL_TRAVEL);

`ifdef SEQ_TIMEOUT_EN
  localparam int PH_W = $clog2(TIMEOUT_CYCLES);
  logic [PH_W-1:0] phase_cnt;
  logic            timeout_trip;

  assign phase_expired = in_phase && (phase_cnt == PH_W'(TIMEOUT_CYCLES - 1));
  // A timeout only counts when the awaited done did not arrive in the same cycle.
  assign timeout_trip  = (nxt == S_FAIL) && phase_expired && !cancel &&
                         !((state == S_STEP) && done_step);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      phase_cnt <= (nxt != state || !in_phase) ? '0 : phase_cnt + PH_W'(1);
      if (state == S_IDLE && nxt == S_TRAVEL)
        timeout_flag <= 1'b0;
      else if (timeout_trip)
        timeout_flag <= 1'b1;
    end
  end
`else
  assign phase_expired = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (start_animation || pending) nxt = S_TRAVEL;
      S_TRAVEL:
        if (cancel)             nxt = S_FAIL;
        else if (done_travel)   nxt = S_STEP;
        else if (phase_expired) nxt = S_FAIL;
      S_STEP:
        if (cancel)                 nxt = S_FAIL;
        else if (done_step) begin
          if (step_fail)                nxt = S_FAIL;
          else if (stage == LAST_STAGE) nxt = S_FINAL_TRAVEL;
          else                          nxt = S_TRAVEL;
        end
        else if (phase_expired)     nxt = S_FAIL;
      S_FINAL_TRAVEL:
        if (cancel)             nxt = S_FAIL;
        else if (done_travel)   nxt = S_DONE;
        else if (phase_expired) nxt = S_FAIL;
      S_DONE:  nxt = S_IDLE;
      S_FAIL:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    step                 = '0;
    travel               = '0;
    busy                 = (state != S_IDLE);
    finished_transaction = (state == S_DONE);
    failed_transaction   = (state == S_FAIL);
    case (state)
      S_TRAVEL: begin
        step   = stage_code;
        travel = stage_code;
      end
      S_STEP:         step   = stage_code;
      S_FINAL_TRAVEL: travel = FINISH_CODE;
      S_DONE:         step   = FINISH_CODE;
      default: ;
    endcase
  end

  // Counters bump on entry to DONE/FAIL so the count is visible with the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage      <= '0;
      pending    <= 1'b0;
      done_count <= '0;
      fail_count <= '0;
    end else begin
      if (state == S_IDLE && nxt == S_TRAVEL)
        stage <= '0;
      else if (state == S_STEP && nxt == S_TRAVEL)
        stage <= stage + 3'd1;

      if (state == S_IDLE)
        pending <= 1'b0;
      else if (start_animation)
        pending <= 1'b1;

      if (nxt == S_DONE && done_count != {CNT_W{1'b1}})
        done_count <= done_count + CNT_W'(1);
      if (nxt == S_FAIL && fail_count != {CNT_W{1'b1}})
        fail_count <= fail_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_txn_stage_sequencer.sv
// tb/tb_txn_stage_sequencer.sv - directed self-checking bench for txn_stage_sequencer.
module tb_txn_stage_sequencer;

  localparam int NS = 4;
  localparam int CW = 3;
  localparam int KW = 2;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_animation = 1'b0;
  logic          done_travel = 1'b0;
  logic          done_step = 1'b0;
  logic          step_fail = 1'b0;
  logic          cancel = 1'b0;
  logic [CW-1:0] step;
  logic [CW-1:0] travel;
  logic          busy;
  logic          finished_transaction;
  logic          failed_transaction;
  logic          pending;
  logic [KW-1:0] done_count;
  logic [KW-1:0] fail_count;
`ifdef SEQ_TIMEOUT_EN
  logic          timeout_flag;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  txn_stage_sequencer #(
    .NUM_STAGES(NS), .CODE_W(CW), .CNT_W(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_animation(start_animation),
    .done_travel(done_travel),
    .done_step(done_step),
    .step_fail(step_fail),
    .cancel(cancel),
    .step(step),
    .travel(travel),
    .busy(busy),
    .finished_transaction(finished_transaction),
    .failed_transaction(failed_transaction),
    .pending(pending),
    .done_count(done_count),
    .fail_count(fail_count)
`ifdef SEQ_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_travel();
    done_travel = 1'b1;
    tick();
    done_travel = 1'b0;
  endtask

  task automatic pulse_step();
    done_step = 1'b1;
    tick();
    done_step = 1'b0;
  endtask

  task automatic kick();
    start_animation = 1'b1;
    tick();
    start_animation = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if ({step, travel} !== 6'd0) begin n_bad++; $display("FAIL reset_codes got=%0d/%0d exp=0/0", step, travel); end
    n_cmp++; if ({busy, finished_transaction, failed_transaction, pending} !== 4'd0) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, finished_transaction, failed_transaction, pending}); end
    n_cmp++; if ({done_count, fail_count} !== 4'd0) begin n_bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", done_count, fail_count); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_nominal();
    kick();
    for (int i = 0; i < NS; i++) begin
      n_cmp++; if (travel !== 3'(i + 1) || step !== 3'(i + 1)) begin n_bad++; $display("FAIL nom_travel%0d got=%0d/%0d exp=%0d/%0d", i, step, travel, i + 1, i + 1); end
      tick(); tick(); pulse_travel();
      n_cmp++; if (step !== 3'(i + 1) || travel !== 3'd0) begin n_bad++; $display("FAIL nom_step%0d got=%0d/%0d exp=%0d/0", i, step, travel, i + 1); end
      tick(); tick(); pulse_step();
    end
    n_cmp++; if (travel !== 3'd5 || step !== 3'd0) begin n_bad++; $display("FAIL nom_final_travel got=%0d/%0d exp=0/5", step, travel); end
    tick(); tick(); pulse_travel();
    n_cmp++; if (finished_transaction !== 1'b1 || step !== 3'd5 || travel !== 3'd0) begin n_bad++; $display("FAIL nom_done got=fin%b step%0d travel%0d exp=fin1 step5 travel0", finished_transaction, step, travel); end
    n_cmp++; if (done_count !== 2'd1) begin n_bad++; $display("FAIL nom_done_count got=%0d exp=1", done_count); end
    tick();
    n_cmp++; if (finished_transaction !== 1'b0 || busy !== 1'b0 || step !== 3'd0) begin n_bad++; $display("FAIL nom_back_idle got=fin%b busy%b step%0d exp=0 0 0", finished_transaction, busy, step); end
  endtask

  task automatic test_step_fail();
    kick(); pulse_travel(); pulse_step(); pulse_travel();
    n_cmp++; if (step !== 3'd2 || travel !== 3'd0) begin n_bad++; $display("FAIL sf_at_step2 got=%0d/%0d exp=2/0", step, travel); end
    done_step = 1'b1; step_fail = 1'b1;
    tick();
    done_step = 1'b0; step_fail = 1'b0;
    n_cmp++; if (failed_transaction !== 1'b1 || fail_count !== 2'd1) begin n_bad++; $display("FAIL sf_pulse got=fail%b cnt%0d exp=1 1", failed_transaction, fail_count); end
    n_cmp++; if ({step, travel} !== 6'd0) begin n_bad++; $display("FAIL sf_codes got=%0d/%0d exp=0/0", step, travel); end
    tick();
    n_cmp++; if (busy !== 1'b0 || travel !== 3'd0 || failed_transaction !== 1'b0) begin n_bad++; $display("FAIL sf_idle got=busy%b travel%0d fail%b exp=0 0 0", busy, travel, failed_transaction); end
    n_cmp++; if (done_count !== 2'd1) begin n_bad++; $display("FAIL sf_done_count got=%0d exp=1", done_count); end
  endtask

  task automatic test_cancel_priority();
    kick();
    cancel = 1'b1; done_travel = 1'b1;
    tick();
    cancel = 1'b0; done_travel = 1'b0;
    n_cmp++; if (failed_transaction !== 1'b1 || step !== 3'd0) begin n_bad++; $display("FAIL cp_fail got=fail%b step%0d exp=1 0", failed_transaction, step); end
    n_cmp++; if (fail_count !== 2'd2 || done_count !== 2'd1) begin n_bad++; $display("FAIL cp_counts got=%0d/%0d exp=1/2", done_count, fail_count); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cp_idle got=%b exp=0", busy); end
  endtask

  task automatic test_pending();
    kick(); pulse_travel(); pulse_step(); pulse_travel(); pulse_step();
    kick();
    n_cmp++; if (pending !== 1'b1 || travel !== 3'd3) begin n_bad++; $display("FAIL pend_set got=pend%b travel%0d exp=1 3", pending, travel); end
    kick();
    pulse_travel(); pulse_step(); pulse_travel(); pulse_step(); pulse_travel();
    n_cmp++; if (finished_transaction !== 1'b1 || pending !== 1'b1 || done_count !== 2'd2) begin n_bad++; $display("FAIL pend_done got=fin%b pend%b cnt%0d exp=1 1 2", finished_transaction, pending, done_count); end
    tick();
    n_cmp++; if (busy !== 1'b0 || step !== 3'd0 || pending !== 1'b1) begin n_bad++; $display("FAIL pend_idle_gap got=busy%b step%0d pend%b exp=0 0 1", busy, step, pending); end
    tick();
    n_cmp++; if (travel !== 3'd1 || pending !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL pend_restart got=travel%0d pend%b busy%b exp=1 0 1", travel, pending, busy); end
  endtask

  task automatic test_async_reset();
    pulse_travel();
    n_cmp++; if (step !== 3'd1 || travel !== 3'd0) begin n_bad++; $display("FAIL ar_in_step got=%0d/%0d exp=1/0", step, travel); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if ({step, travel, busy, finished_transaction, failed_transaction, pending} !== 10'd0) begin n_bad++; $display("FAIL ar_outputs got=%b exp=0", {step, travel, busy, finished_transaction, failed_transaction, pending}); end
    n_cmp++; if ({done_count, fail_count} !== 4'd0) begin n_bad++; $display("FAIL ar_counts got=%0d/%0d exp=0/0", done_count, fail_count); end
    #2 reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || failed_transaction !== 1'b0) begin n_bad++; $display("FAIL ar_after got=busy%b fail%b exp=0 0", busy, failed_transaction); end
  endtask

  task automatic test_ignored();
    kick();
    done_step = 1'b1;
    tick();
    done_step = 1'b0;
    n_cmp++; if (travel !== 3'd1 || step !== 3'd1) begin n_bad++; $display("FAIL ig_step_in_travel got=%0d/%0d exp=1/1", step, travel); end
    done_travel = 1'b1; done_step = 1'b1;
    tick();
    done_travel = 1'b0; done_step = 1'b0;
    n_cmp++; if (step !== 3'd1 || travel !== 3'd0) begin n_bad++; $display("FAIL ig_both got=%0d/%0d exp=1/0", step, travel); end
    pulse_travel();
    n_cmp++; if (step !== 3'd1 || travel !== 3'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL ig_travel_in_step got=%0d/%0d exp=1/0", step, travel); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_cmp++; if (failed_transaction !== 1'b1 || fail_count !== 2'd1) begin n_bad++; $display("FAIL ig_cancel_step got=fail%b cnt%0d exp=1 1", failed_transaction, fail_count); end
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_cmp++; if (busy !== 1'b0 || failed_transaction !== 1'b0 || fail_count !== 2'd1) begin n_bad++; $display("FAIL ig_cancel_idle got=busy%b fail%b cnt%0d exp=0 0 1", busy, failed_transaction, fail_count); end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 5; k++) begin
      kick();
      for (int s = 0; s < NS; s++) begin
        pulse_travel(); pulse_step();
      end
      pulse_travel();
      n_cmp++; if (finished_transaction !== 1'b1) begin n_bad++; $display("FAIL sat_fin%0d got=%b exp=1", k, finished_transaction); end
      if (k == 3) begin
        n_cmp++; if (done_count !== 2'd3) begin n_bad++; $display("FAIL sat_at3 got=%0d exp=3", done_count); end
      end
      tick();
    end
    n_cmp++; if (done_count !== 2'd3) begin n_bad++; $display("FAIL sat_done_count got=%0d exp=3", done_count); end
    for (int k = 0; k < 3; k++) begin
      kick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
    end
    n_cmp++; if (fail_count !== 2'd3) begin n_bad++; $display("FAIL sat_fail_count got=%0d exp=3", fail_count); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    kick();
    for (int i = 0; i < TO; i++) begin
      n_cmp++; if (travel !== 3'd1 || failed_transaction !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d got=travel%0d fail%b exp=1 0", i, travel, failed_transaction); end
      tick();
    end
    n_cmp++; if (failed_transaction !== 1'b1 || timeout_flag !== 1'b1) begin n_bad++; $display("FAIL to_fire got=fail%b flag%b exp=1 1", failed_transaction, timeout_flag); end
    tick();
    n_cmp++; if (timeout_flag !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL to_hold got=flag%b busy%b exp=1 0", timeout_flag, busy); end
    kick();
    n_cmp++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL to_clear got=%b exp=0", timeout_flag); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_step_fail();
    test_cancel_priority();
    test_pending();
    test_async_reset();
    test_ignored();
    test_saturation();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
